// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock's BCD time/date field counters.
// Pure declarations: no logic, no latency, no flow control.
package clock_pkg;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] HOUR_MAX  = 8'h23;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] DAY_MIN   = 8'h01;

    // Which button currently owns the hold/auto-repeat counter.
    typedef enum logic [1:0] {
        BTN_IDLE = 2'd0,
        BTN_UP   = 2'd1,
        BTN_DOWN = 2'd2
    } btn_state_t;

    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Decimal +1 / -1 of a multi-digit BCD word; purely combinational, zero latency,
// no flow control. Wraps modulo 10^DIGITS; non-BCD input digits are treated as 9.
module bcd_step
    import clock_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic                dir,
    output logic [4*DIGITS-1:0] result
);

    logic [3:0] digit;
    logic       ripple;

    always_comb begin
        result = '0;
        ripple = 1'b1;
        digit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd_digit_valid(value[4*i +: 4]) ? value[4*i +: 4] : 4'd9;
            if (!ripple) begin
                result[4*i +: 4] = digit;
            end else if (dir) begin
                if (digit == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = digit + 4'd1;
                    ripple           = 1'b0;
                end
            end else begin
                if (digit == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = digit - 4'd1;
                    ripple           = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dem_bcd_mod.sv
// BCD modulo counter for one clock field with cascaded carry and button set mode.
// Value updates one cycle after enable/press; carry_out is combinational; no backpressure.
module dem_bcd_mod
    import clock_pkg::*;
#(
    parameter int                   DIGITS       = 2,
    parameter logic [4*DIGITS-1:0]  MIN_VAL      = '0,
    parameter logic [4*DIGITS-1:0]  MAX_VAL      = SEC_MAX,
    parameter bit                   USE_DYN_MAX  = 1'b0,
    parameter int                   HOLD_TICKS   = 2,
    parameter int                   REPEAT_TICKS = 1
) (
    input  logic                clk_1Hz,
    input  logic                rst_n,
    input  logic                cnt_en,
    input  logic                set_en,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic [4*DIGITS-1:0] max_val,
    output logic [4*DIGITS-1:0] value,
    output logic                carry_out
);

    localparam int W  = 4 * DIGITS;
    localparam int HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_AT   = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] REPEAT_AT = HW'(HOLD_TICKS + REPEAT_TICKS);

    logic [W-1:0]  eff_max;
    logic [W-1:0]  step_res;
    logic [W-1:0]  value_nxt;
    logic          step_dir;
    logic          at_max;
    logic          at_min;
    logic          over_max;
    logic          hist_up;
    logic          hist_dn;
    logic          up_press;
    logic          dn_press;
    logic          do_up;
    logic          do_dn;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [HW-1:0] hold_inc;
    logic [HW-1:0] rpt_cnt;
    logic          rpt_step;
    btn_state_t    btn_state;
    btn_state_t    btn_state_nxt;

    // max_val is only consumed when USE_DYN_MAX is set.
    logic unused_max_bits;
    assign unused_max_bits = ^max_val;

    // Non-BCD digits of the limit saturate to 9 so a clamp can never load a bad digit.
    always_comb begin
        eff_max = USE_DYN_MAX ? max_val : MAX_VAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(eff_max[4*i +: 4])) begin
                eff_max[4*i +: 4] = 4'd9;
            end
        end
    end

    assign at_max    = (value == eff_max);
    assign at_min    = (value == MIN_VAL);
    assign over_max  = (value > eff_max);
    assign carry_out = cnt_en & ~set_en & at_max;

    assign up_press = hist_up & ~btn_up;
    assign dn_press = hist_dn & ~btn_down & btn_up;

    // Hold counter parks in [HOLD_AT, REPEAT_AT) once auto-repeat is running.
    assign hold_inc = hold_cnt + 1'b1;
    assign rpt_step = (hold_inc == HOLD_AT) || (hold_inc == REPEAT_AT);
    assign rpt_cnt  = (hold_inc == REPEAT_AT) ? HOLD_AT : hold_inc;

    always_comb begin
        btn_state_nxt = btn_state;
        hold_nxt      = hold_cnt;
        do_up         = 1'b0;
        do_dn         = 1'b0;
        if (!set_en) begin
            btn_state_nxt = BTN_IDLE;
            hold_nxt      = '0;
        end else if (up_press) begin
            btn_state_nxt = BTN_UP;
            hold_nxt      = '0;
            do_up         = 1'b1;
        end else if (dn_press) begin
            btn_state_nxt = BTN_DOWN;
            hold_nxt      = '0;
            do_dn         = 1'b1;
        end else begin
            case (btn_state)
                BTN_UP: begin
                    if (!btn_up) begin
                        hold_nxt = rpt_cnt;
                        do_up    = rpt_step;
                    end else begin
                        btn_state_nxt = BTN_IDLE;
                        hold_nxt      = '0;
                    end
                end
                BTN_DOWN: begin
                    if (!btn_down) begin
                        hold_nxt = rpt_cnt;
                        do_dn    = rpt_step;
                    end else begin
                        btn_state_nxt = BTN_IDLE;
                        hold_nxt      = '0;
                    end
                end
                default: begin
                    btn_state_nxt = BTN_IDLE;
                    hold_nxt      = '0;
                end
            endcase
        end
    end

    assign step_dir = ~do_dn;

    bcd_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .value  (value),
        .dir    (step_dir),
        .result (step_res)
    );

    always_comb begin
        value_nxt = value;
        if (over_max) begin
            value_nxt = eff_max;
        end else if (do_up) begin
            value_nxt = at_max ? MIN_VAL : step_res;
        end else if (do_dn) begin
            value_nxt = at_min ? eff_max : step_res;
        end else if (!set_en && cnt_en) begin
            value_nxt = at_max ? MIN_VAL : step_res;
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            value     <= MIN_VAL;
            hist_up   <= 1'b1;
            hist_dn   <= 1'b1;
            hold_cnt  <= '0;
            btn_state <= BTN_IDLE;
        end else begin
            value     <= value_nxt;
            hist_up   <= btn_up;
            hist_dn   <= btn_down;
            hold_cnt  <= hold_nxt;
            btn_state <= btn_state_nxt;
        end
    end

endmodule

// File: doc/dem_bcd_mod.md
Name: dem_bcd_mod

Overview:
- Generalised BCD modulo counter for the clock's time/date fields: seconds, minutes, hours, day, month, year-of-century.
- Counts on a per-cycle enable, so fields cascade via carry_out on the same clk_1Hz domain.
- In set mode it is adjusted with active-low up/down buttons: single step on press, auto-repeat while held.
- Supports non-zero minimum (day/month start at 01) and a run-time maximum (days-in-month).

Parameters:
- DIGITS, 2: number of BCD digits; count width is 4*DIGITS.
- MIN_VAL, 8'h00: BCD value after reset and after wrap-up.
- MAX_VAL, 8'h59: static BCD maximum.
- USE_DYN_MAX, 0: when 1, the max_val port replaces MAX_VAL.
- HOLD_TICKS, 2: cycles a button must be held before auto-repeat starts.
- REPEAT_TICKS, 1: cycles between auto-repeat steps.

Ports:
- clk_1Hz  input  1  counter clock.
- rst_n  input  1  asynchronous active-low reset.
- cnt_en  input  1  count-up enable (tie 1 for seconds; previous field's carry_out otherwise).
- set_en  input  1  set mode for this field, already decoded from mode by the parent.
- btn_up  input  1  increment button, active-low.
- btn_down  input  1  decrement button, active-low.
- max_val  input  4*DIGITS  dynamic BCD maximum; ignored when USE_DYN_MAX=0.
- value  output  4*DIGITS  current BCD count.
- carry_out  output  1  combinational wrap pulse used to enable the next field.

Behaviour:
- Clock and reset: one clock, clk_1Hz; reset is asynchronous and active-low on rst_n.
- Reset values: value=MIN_VAL, button history=released (1), hold counter=0, carry_out=0.
- Effective max: eff_max = USE_DYN_MAX ? max_val : MAX_VAL.
- Arithmetic:
  - +1 and -1 are decimal, digit by digit; a digit never leaves the range 0-9.
  - Width is exactly 4*DIGITS with no overflow beyond the top digit.
- Count mode (set_en=0):
  - If cnt_en=1: value==eff_max -> MIN_VAL, else value+1.
  - If cnt_en=0: hold.
  - carry_out = cnt_en & ~set_en & (value==eff_max), combinational, so the next field steps on the same edge.
- Set mode (set_en=1):
  - cnt_en is ignored and carry_out=0.
  - Buttons are sampled into a one-cycle history register.
  - Press edge = history 1 and current 0.
  - On a press edge of the selected button, step once.
  - Hold counter clears on any press edge or release. While the button stays low it increments; when it reaches HOLD_TICKS, a step occurs and then repeats every REPEAT_TICKS cycles.
  - Up step: value==eff_max -> MIN_VAL, else +1.
  - Down step: value==MIN_VAL -> eff_max, else -1.
  - Both buttons low: up has priority; down is ignored until up is released.
- Dynamic max shrink: if value > eff_max at any edge (e.g. day 31 when the month changes to 30), value clamps to eff_max on that edge. The clamp overrides stepping and counting; carry_out is 0 on that cycle.
- Mode change: entering or leaving set mode mid-hold clears the hold counter. No step on the transition edge unless a fresh press edge occurs.
- Invalid input: a non-BCD max_val is outside the contract; behaviour is undefined but must not produce a non-BCD value digit.
- Reset mid-operation: the asynchronous clear wins immediately; no step is taken on the first edge after release unless a new press edge occurs.

Decomposition:
- Shared package clock_pkg:
  - BCD literal constants: SEC_MAX=8'h59, HOUR_MAX=8'h23, MONTH_MAX=8'h12, DAY_MIN=8'h01.
  - Function bcd_digit_valid.
- One combinational sub-module, bcd_step:
  - Parametrised by DIGITS; inputs value and dir; output the ±1 result.
  - Instantiated once and shared by count and set paths.
  - Supersedes the separate plus-1/minus-1 helpers.
- Button history and hold/repeat counter stay inline.

Test Plan:
- Seconds config (defaults), set_en=0, cnt_en=1, reset at value 00 -> 59 edges to reach 59 with carry_out=1 only while value==59; next edge gives 00.
- Day config (MIN_VAL=01, USE_DYN_MAX=1, max_val=31) at value 31 -> wraps to 01 with carry_out=1. Then set max_val=30 at value 31 -> clamps to 30 on the next edge, carry_out=0.
- set_en=1, value 00, btn_down pulsed low for one cycle -> 59 after one edge, then holds. btn_up pulsed at 59 -> 00.
- set_en=1, HOLD_TICKS=2, REPEAT_TICKS=1, btn_up held low from value 10 -> 11 on the press edge, then 12, 13, 14 on successive edges after the hold threshold.
- set_en=1, both buttons low at 20 -> increments only. Release btn_up while btn_down is still low -> no step until btn_down is released and pressed again.
- Hours config (MAX_VAL=8'h23), cnt_en=1; assert rst_n low asynchronously between edges at 17 -> value=00 immediately; the counter resumes from 00.
